// File: rtl/qspi_flash_pkg.sv
// Shared opcodes and FSM encoding for the SPI NOR flash responder.
package qspi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives
// single-cycle edge pulses for SCK and chip select.
module spi_pin_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_mosi
);

  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_cs_meta, r_cs_sync, r_cs_prev, r_cs_armed;
  logic r_mosi_meta, r_mosi_sync;

  // CS only arms after it has been seen high, so a select held low across
  // reset cannot start a transaction without a fresh falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_cs_meta   <= 1'b0;
      r_cs_sync   <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_cs_armed  <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_sck_meta  <= i_sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_cs_meta   <= i_cs_n;
      r_cs_sync   <= r_cs_meta;
      r_cs_prev   <= r_cs_sync;
      r_cs_armed  <= r_cs_armed | r_cs_sync;
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign o_sck_rise = r_sck_sync & ~r_sck_prev;
  assign o_sck_fall = ~r_sck_sync & r_sck_prev;
  assign o_cs_fall  = r_cs_armed & r_cs_prev & ~r_cs_sync;
  assign o_cs_rise  = r_cs_sync & ~r_cs_prev;
  assign o_mosi     = r_mosi_sync;

endmodule

// File: rtl/qspi_flash_responder.sv
// Single-lane SPI NOR flash responder (READ/RDID/RDSR) backed by a
// byte-wide memory port, for booting the SoC from block RAM.
module qspi_flash_responder
  import qspi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              cmd_err,
  output logic [2:0]        dbg_state
);

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi;

  spi_pin_sync u_sync (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sck      (spi_sck),
    .i_cs_n     (spi_cs_n),
    .i_mosi     (spi_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise),
    .o_mosi     (w_mosi)
  );

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_bit_cnt;
  logic [22:0]       r_rx;
  logic [7:0]        r_tx, r_buf;
  logic              r_pending, r_miso, r_oe, r_mem_req, r_cmd_err;
  logic [ADDR_W-1:0] r_addr;
  logic              w_cmd_bad;
  logic [7:0]        w_opcode;
  logic [23:0]       w_addr_full;

  assign w_opcode    = {r_rx[6:0], w_mosi};
  assign w_addr_full = {r_rx, w_mosi};

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_bad   = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
        ST_CMD: begin
          if (w_sck_rise && r_bit_cnt == 5'd7) begin
            case (w_opcode)
              OP_READ: w_state_nxt = ST_ADDR;
              OP_RDID: w_state_nxt = ST_ID;
              OP_RDSR: w_state_nxt = ST_STAT;
              default: begin
                w_state_nxt = ST_IGNORE;
                w_cmd_bad   = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: if (w_sck_rise && r_bit_cnt == 5'd23) w_state_nxt = ST_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Memory port: mem_req is a one-cycle pulse with mem_addr valid alongside;
  // exactly one mem_rvalid pulse answers each request, with no back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_buf     <= '0;
      r_pending <= 1'b0;
      r_miso    <= 1'b0;
      r_oe      <= 1'b0;
      r_mem_req <= 1'b0;
      r_cmd_err <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_cmd_err <= 1'b0;
      if (mem_rvalid && r_pending) begin
        r_pending <= 1'b0;
        if (r_state == ST_DATA && !w_cs_rise) r_buf <= mem_rdata;
      end
      if (w_cs_rise) begin
        r_miso    <= 1'b0;
        r_oe      <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_cs_fall) r_bit_cnt <= '0;
          ST_CMD: begin
            if (w_sck_rise) begin
              r_rx      <= {r_rx[21:0], w_mosi};
              r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
              r_cmd_err <= w_cmd_bad;
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_rx <= {r_rx[21:0], w_mosi};
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= '0;
                r_mem_req <= 1'b1;
                r_pending <= 1'b1;
                r_addr    <= w_addr_full[ADDR_W-1:0];
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_DATA: begin
            if (w_sck_fall) begin
              r_oe      <= 1'b1;
              r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
              if (r_bit_cnt[2:0] == 3'd0) begin
                // MSB of a new byte goes out; prefetch the next address now.
                r_miso    <= r_buf[7];
                r_tx      <= {r_buf[6:0], 1'b0};
                r_mem_req <= 1'b1;
                r_pending <= 1'b1;
                r_addr    <= r_addr + ADDR_W'(1);
              end else begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
            end
          end
          ST_ID: begin
            if (w_sck_fall) begin
              r_oe <= 1'b1;
              if (r_bit_cnt < 5'd24) begin
                r_miso    <= JEDEC_ID[5'd23 - r_bit_cnt];
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end else begin
                r_miso <= 1'b0;
              end
            end
          end
          ST_STAT: begin
            if (w_sck_fall) begin
              r_oe      <= 1'b1;
              r_miso    <= STATUS[3'd7 - r_bit_cnt[2:0]];
              r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe & ~w_cs_rise;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_addr;
  assign busy        = (r_state != ST_IDLE);
  assign cmd_err     = r_cmd_err;
  assign dbg_state   = r_state;

endmodule
